// File: rtl/decoder_4to16.sv
// 4-to-16 one-hot decoder with a combinational output and a registered copy.
// Optional select capture outputs enabled by defining DECODER_SEL_CAPTURE_EN.
module decoder_4to16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in,
    output logic [15:0] enable,
    output logic [15:0] enable_q
`ifdef DECODER_SEL_CAPTURE_EN
    ,
    output logic [3:0]  sel_q,
    output logic        sel_valid_q
`endif
);

    logic [15:0] enable_d;

    // Explicit table so an unknown select falls to the all-zero default
    always_comb begin
        enable = 16'h0000;
        case (in)
            4'd0:    enable = 16'h0001;
            4'd1:    enable = 16'h0002;
            4'd2:    enable = 16'h0004;
            4'd3:    enable = 16'h0008;
            4'd4:    enable = 16'h0010;
            4'd5:    enable = 16'h0020;
            4'd6:    enable = 16'h0040;
            4'd7:    enable = 16'h0080;
            4'd8:    enable = 16'h0100;
            4'd9:    enable = 16'h0200;
            4'd10:   enable = 16'h0400;
            4'd11:   enable = 16'h0800;
            4'd12:   enable = 16'h1000;
            4'd13:   enable = 16'h2000;
            4'd14:   enable = 16'h4000;
            4'd15:   enable = 16'h8000;
            default: enable = 16'h0000;
        endcase
    end

    always_comb begin
        enable_d = enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 16'h0000;
        end else begin
            enable_q <= enable_d;
        end
    end

`ifdef DECODER_SEL_CAPTURE_EN
    logic [3:0] sel_d;
    logic       sel_valid_d;

    always_comb begin
        sel_d       = in;
        sel_valid_d = |enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 4'h0;
            sel_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_4to16.sv
// Directed self-checking bench for decoder_4to16.
// Covers sweep, unknown select, latency, async reset and glitch rejection.
module tb_decoder_4to16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in;
    logic [15:0] enable;
    logic [15:0] enable_q;
`ifdef DECODER_SEL_CAPTURE_EN
    logic [3:0]  sel_q;
    logic        sel_valid_q;
`endif

    int n_chk;
    int n_fail;

    decoder_4to16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .enable      (enable),
        .enable_q    (enable_q)
`ifdef DECODER_SEL_CAPTURE_EN
        ,
        .sel_q       (sel_q),
        .sel_valid_q (sel_valid_q)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A 2-state simulator cannot hold X, so model from what was really driven
    function automatic logic [15:0] model(input logic [3:0] s);
        if ($isunknown(s)) return 16'h0000;
        return 16'h0001 << s;
    endfunction

    initial begin
        logic [15:0] x_exp;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        in     = 4'd0;
        #1;
        chk("reset_enable_q", enable_q, 16'h0000);
        chk("reset_enable", enable, 16'h0001);

        for (int i = 0; i < 16; i++) begin
            in = 4'(i);
            #5;
            chk($sformatf("sweep_%0d", i), enable, 16'h0001 << i);
            if (i == 5)  chk("sweep_in5", enable, 16'h0020);
            if (i == 15) chk("sweep_in15", enable, 16'h8000);
        end
        chk("reset_hold", enable_q, 16'h0000);

        in = 4'bxxxx;
        x_exp = model(in);
        #1;
        chk("unknown_comb", enable, x_exp);
        chk("unknown_no_x", {15'd0, $isunknown(enable)}, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        in    = 4'd3;
        #1;
        chk("latency_before", enable_q, 16'h0000);
        @(posedge clk);
        #1;
        chk("latency_after", enable_q, 16'h0008);

        @(negedge clk);
        in = 4'd14;
        @(posedge clk);
        #1;
        chk("pre_reset_q", enable_q, 16'h4000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_q", enable_q, 16'h0000);
        chk("async_reset_comb", enable, 16'h4000);
        @(posedge clk);
        #1;
        chk("reset_hold_edge", enable_q, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        in    = 4'd2;
        #1 in = 4'd9;
        #1;
        chk("glitch_comb", enable, 16'h0200);
        in = 4'd2;
        @(posedge clk);
        #1;
        chk("glitch_reject", enable_q, 16'h0004);

        @(negedge clk);
        in = 4'bxxxx;
        x_exp = model(in);
        @(posedge clk);
        #1;
        chk("unknown_reg", enable_q, x_exp);

`ifdef DECODER_SEL_CAPTURE_EN
        @(negedge clk);
        in = 4'd10;
        @(posedge clk);
        #1;
        chk("sel_q", {12'd0, sel_q}, 16'h000A);
        chk("sel_valid_known", {15'd0, sel_valid_q}, 16'h0001);
        @(negedge clk);
        in = 4'bxxxx;
        x_exp = model(in);
        @(posedge clk);
        #1;
        chk("sel_valid_unknown", {15'd0, sel_valid_q},
            {15'd0, |x_exp});
        #2;
        rst_n = 1'b0;
        #1;
        chk("sel_reset", {11'd0, sel_valid_q, sel_q}, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
